// File: rtl/idct_block_sink.sv
// Ping-pong sink turning IDCT samples into clamped 8-bit pixels; a full block starts streaming two clocks after its last sample.
// Valid/ready output holds while out_ready is low; a block arriving with both banks occupied is dropped and flagged.
module idct_block_sink #(
  parameter int BitWidth = 31,
  parameter int PixLsb   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [BitWidth:0] din,
  output logic [7:0]        out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow,
  output logic              short_block,
  output logic [15:0]       block_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_LOW} cap_state_e;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  cap_state_e  state_q, state_d;
  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic [5:0]  idx_q, idx_d;
  logic        cap_bank_q, cap_bank_d;
  logic        armed_q;
  logic        first_full_q, first_full_d;
  logic        drain_q, drain_d;
  logic [5:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  pix_q, pix_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        ovf_q, ovf_d;
  logic        short_q, short_d;
  logic [15:0] count_q, count_d;

  logic        wr_en;
  logic        wr_bank;
  logic [5:0]  wr_idx;
  logic        drain_act;
  logic        xfer;
  logic [7:0]  mem_q [128];

  logic signed [BitWidth:0] shifted;
  logic [7:0]               din_pix;

  assign shifted = $signed(din) >>> PixLsb;

  always_comb begin
    if (shifted < 0)        din_pix = 8'h00;
    else if (shifted > 255) din_pix = 8'hFF;
    else                    din_pix = shifted[7:0];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cap_bank_d   = cap_bank_q;
    first_full_d = first_full_q;
    ovf_d        = ovf_q;
    short_d      = short_q;
    bank_d       = bank_q;
    wr_en        = 1'b0;
    wr_bank      = cap_bank_q;
    wr_idx       = idx_q;
    drain_d      = drain_q;
    rd_idx_d     = rd_idx_q;
    pix_d        = pix_q;
    valid_d      = valid_q;
    last_d       = last_q;
    count_d      = count_q;
    drain_act    = (bank_q[drain_q] == DRAINING);
    xfer         = valid_q & out_ready;

    // armed_q remembers done was low last cycle, so a block held over reset is skipped
    case (state_q)
      IDLE: begin
        if (done) begin
          if (!armed_q) begin
            state_d = WAIT_LOW;
          end else if (bank_q[0] == EMPTY || bank_q[1] == EMPTY) begin
            cap_bank_d         = (bank_q[0] == EMPTY) ? 1'b0 : 1'b1;
            wr_en              = 1'b1;
            wr_bank            = cap_bank_d;
            wr_idx             = 6'd0;
            bank_d[cap_bank_d] = FILLING;
            idx_d              = 6'd1;
            state_d            = CAPTURE;
          end else begin
            ovf_d   = 1'b1;
            state_d = WAIT_LOW;
          end
        end
      end
      CAPTURE: begin
        if (done) begin
          wr_en = 1'b1;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            bank_d[cap_bank_q] = FULL;
            if (bank_q[~cap_bank_q] != FULL) first_full_d = cap_bank_q;
            state_d = WAIT_LOW;
          end
        end else begin
          short_d            = 1'b1;
          bank_d[cap_bank_q] = EMPTY;
          idx_d              = 6'd0;
          state_d            = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (xfer && last_q) begin
      bank_d[drain_q] = EMPTY;
      valid_d         = 1'b0;
      last_d          = 1'b0;
      rd_idx_d        = 6'd0;
      count_d         = count_q + 16'd1;
    end else if (drain_act && (!valid_q || xfer)) begin
      pix_d    = mem_q[{drain_q, rd_idx_q}];
      valid_d  = 1'b1;
      last_d   = (rd_idx_q == 6'd63);
      rd_idx_d = rd_idx_q + 6'd1;
    end

    // hand over to the next full bank in the same cycle the current one empties
    if (!drain_act || (xfer && last_q)) begin
      if (bank_q[0] == FULL && bank_q[1] == FULL) begin
        drain_d              = first_full_q;
        bank_d[first_full_q] = DRAINING;
      end else if (bank_q[0] == FULL) begin
        drain_d   = 1'b0;
        bank_d[0] = DRAINING;
      end else if (bank_q[1] == FULL) begin
        drain_d   = 1'b1;
        bank_d[1] = DRAINING;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 6'd0;
      cap_bank_q   <= 1'b0;
      armed_q      <= 1'b0;
      first_full_q <= 1'b0;
      bank_q[0]    <= EMPTY;
      bank_q[1]    <= EMPTY;
      drain_q      <= 1'b0;
      rd_idx_q     <= 6'd0;
      pix_q        <= 8'h00;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      ovf_q        <= 1'b0;
      short_q      <= 1'b0;
      count_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cap_bank_q   <= cap_bank_d;
      armed_q      <= ~done;
      first_full_q <= first_full_d;
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      drain_q      <= drain_d;
      rd_idx_q     <= rd_idx_d;
      pix_q        <= pix_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      ovf_q        <= ovf_d;
      short_q      <= short_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank, wr_idx}] <= din_pix;
  end

  assign out_pixel   = pix_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign overflow    = ovf_q;
  assign short_block = short_q;
  assign block_count = count_q;

endmodule
